// File: rtl/fmul_arbiter_if.sv
// Bundle of requester, multiplier-IP and response signals around fmul_arbiter.
// master = environment side (requesters + IP), slave = the arbiter itself.
interface fmul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ*DATA_W-1:0] req_a_in;
    logic [NUM_REQ*DATA_W-1:0] req_b_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [DATA_W-1:0]         mult_a_out;
    logic [DATA_W-1:0]         mult_b_out;
    logic                      mult_valid_out;
    logic [DATA_W-1:0]         mult_result_in;
    logic                      mult_valid_in;
    logic [NUM_REQ-1:0]        resp_valid_out;
    logic [DATA_W-1:0]         resp_data_out;
    logic                      busy_out;
    logic                      err_out;

    modport master (
        output req_valid_in, req_a_in, req_b_in, mult_result_in, mult_valid_in,
        input  req_ready_out, mult_a_out, mult_b_out, mult_valid_out,
               resp_valid_out, resp_data_out, busy_out, err_out
    );

    modport slave (
        input  req_valid_in, req_a_in, req_b_in, mult_result_in, mult_valid_in,
        output req_ready_out, mult_a_out, mult_b_out, mult_valid_out,
               resp_valid_out, resp_data_out, busy_out, err_out
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Shares one pipelined float multiplier among NUM_REQ requesters and routes products back.
// Define FMUL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fmul_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 6,
    parameter int DATA_W       = 32
) (
    input  logic          clk_in,
    input  logic          rst_in,
    fmul_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MULT_LATENCY + 2);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;

    logic [DATA_W-1:0]  mult_a;
    logic [DATA_W-1:0]  mult_b;
    logic               mult_valid;
    logic [ID_W-1:0]    issue_id;

    tag_t               tags [MULT_LATENCY];
    tag_t               tail;

    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_W-1:0]  resp_data;
    logic [CNT_W-1:0]   mask_cnt;
    logic               err;
    logic               busy;

`ifndef FMUL_ARB_FIXED_PRIO_EN
    // Index where the next round-robin search begins (one past the last grant).
    logic [ID_W-1:0]    rr_ptr;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end
`endif

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FMUL_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + k) % NUM_REQ;
`endif
            if (!rst_in && !grant_any && bus.req_valid_in[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mult_a     <= '0;
            mult_b     <= '0;
            mult_valid <= 1'b0;
            issue_id   <= '0;
        end else begin
            mult_valid <= grant_any;
            if (grant_any) begin
                mult_a   <= bus.req_a_in[int'(grant_id)*DATA_W +: DATA_W];
                mult_b   <= bus.req_b_in[int'(grant_id)*DATA_W +: DATA_W];
                issue_id <= grant_id;
            end
        end
    end

    // NOTE: the tag array is a handful of flops, not a RAM, and must be cleared so
    // results of ops in flight at reset find an invalid tail and are dropped.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < MULT_LATENCY; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: mult_valid, id: issue_id};
            for (int i = 1; i < MULT_LATENCY; i++) tags[i] <= tags[i-1];
        end
    end

    assign tail = tags[MULT_LATENCY-1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (bus.mult_valid_in && tail.valid) begin
                resp_valid <= NUM_REQ'(1) << tail.id;
                resp_data  <= bus.mult_result_in;
            end
        end
    end

    // The IP may still emit results of pre-reset ops; ignore mismatches until they drain.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mask_cnt <= CNT_W'(MULT_LATENCY + 1);
            err      <= 1'b0;
        end else if (mask_cnt != '0) begin
            mask_cnt <= mask_cnt - 1'b1;
        end else if (bus.mult_valid_in != tail.valid) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        busy = mult_valid | (|resp_valid);
        for (int i = 0; i < MULT_LATENCY; i++) busy = busy | tags[i].valid;
    end

    assign bus.req_ready_out  = grant;
    assign bus.mult_a_out     = mult_a;
    assign bus.mult_b_out     = mult_b;
    assign bus.mult_valid_out = mult_valid;
    assign bus.resp_valid_out = resp_valid;
    assign bus.resp_data_out  = resp_data;
    assign bus.busy_out       = busy;
    assign bus.err_out        = err;
endmodule
